// File: rtl/cordic_nco_sequencer.sv
// rtl/cordic_nco_sequencer.sv - phase accumulator and request sequencer driving an iterative CORDIC rotator as an NCO
//
// Purpose: on each enabled sample tick, folds the accumulated phase into the
// rotator's convergence range and issues one rotation request. It then waits
// for the rotator's done strobe, applies quadrant sign correction, and presents
// cos/sin with a one-cycle valid strobe.
//
// Ports:
//   clk_i, rst_i (async, active-high)    clock and reset
//   enable_i, tick_i                     sample request (tick honoured only when enabled)
//   phase_inc_i                          unsigned phase step, applied when a sample completes
//   phase_clr_i                          phase reset request (immediate when idle, deferred when busy)
//   cordic_x_o/y_o/z_o, cordic_valid_strobe_o   rotator operands and request strobe
//   cordic_x_i/y_i, cordic_done_i        rotator results and done strobe
//   cos_o, sin_o, sample_valid_strobe_o  corrected sample and its strobe
//   busy_o                               request in flight
//   overrun_o                            sticky: an enabled tick arrived while busy
module cordic_nco_sequencer #(
    parameter int N_FRAC    = 7,
    parameter int PHASE_BW  = 16,
    parameter int AMPLITUDE = 77
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                tick_i,
    input  logic [PHASE_BW-1:0] phase_inc_i,
    input  logic                phase_clr_i,
    output logic [N_FRAC:0]     cordic_x_o,
    output logic [N_FRAC:0]     cordic_y_o,
    output logic [N_FRAC:0]     cordic_z_o,
    output logic                cordic_valid_strobe_o,
    input  logic [N_FRAC:0]     cordic_x_i,
    input  logic [N_FRAC:0]     cordic_y_i,
    input  logic                cordic_done_i,
    output logic [N_FRAC:0]     cos_o,
    output logic [N_FRAC:0]     sin_o,
    output logic                sample_valid_strobe_o,
    output logic                busy_o,
    output logic                overrun_o
);
    localparam int W = N_FRAC + 1;
    localparam logic [W-1:0] AMP     = W'(AMPLITUDE);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

    state_t              state_q, state_d;
    logic [PHASE_BW-1:0] phase_q, phase_d;
    logic                clr_pend_q, clr_pend_d;
    logic                fold_q, fold_d;
    logic                overrun_q, overrun_d;
    logic [W-1:0]        cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [W-1:0]        cos_q, cos_d, sin_q, sin_d;

    logic [PHASE_BW-1:0] phase_src;
    logic [W-1:0]        raw_p, folded_z;
    logic                fold_now, busy, tick_en;

    // Two's-complement negation, clamped so the most negative code maps to the most positive.
    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
        if (v == MOST_NEG) begin
            return MOST_POS;
        end
        return W'(-v);
    endfunction

    // A clear in the same cycle as an accepted tick must already affect the
    // issued phase, so the fold is computed from the post-clear value.
    assign phase_src = phase_clr_i ? '0 : phase_q;
    assign raw_p     = phase_src[PHASE_BW-1 -: W];
    // Top two bits disagree => outside +-pi/2; rotate by pi (flip MSB) and negate the result later.
    assign fold_now  = raw_p[W-1] ^ raw_p[W-2];
    assign folded_z  = fold_now ? {~raw_p[W-1], raw_p[W-2:0]} : raw_p;
    assign busy      = (state_q != S_IDLE);
    assign tick_en   = tick_i & enable_i;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        clr_pend_d = clr_pend_q;
        fold_d     = fold_q;
        overrun_d  = overrun_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        cz_d       = cz_q;
        cos_d      = cos_q;
        sin_d      = sin_q;

        if (busy && tick_en) begin
            overrun_d = 1'b1;
        end
        if (busy && phase_clr_i) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (phase_clr_i) begin
                    phase_d = '0;
                end
                if (tick_en) begin
                    // Operands are latched on entry so they are valid alongside the ISSUE strobe.
                    cx_d    = AMP;
                    cy_d    = '0;
                    cz_d    = folded_z;
                    fold_d  = fold_now;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cordic_done_i) begin
                    cos_d   = fold_q ? neg_sat(cordic_x_i) : cordic_x_i;
                    sin_d   = fold_q ? neg_sat(cordic_y_i) : cordic_y_i;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                phase_d    = (clr_pend_q || phase_clr_i) ? '0 : phase_q + phase_inc_i;
                clr_pend_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            clr_pend_q <= 1'b0;
            fold_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            cz_q       <= '0;
            cos_q      <= '0;
            sin_q      <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            clr_pend_q <= clr_pend_d;
            fold_q     <= fold_d;
            overrun_q  <= overrun_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            cz_q       <= cz_d;
            cos_q      <= cos_d;
            sin_q      <= sin_d;
        end
    end

    assign cordic_x_o            = cx_q;
    assign cordic_y_o            = cy_q;
    assign cordic_z_o            = cz_q;
    assign cordic_valid_strobe_o = (state_q == S_ISSUE);
    assign cos_o                 = cos_q;
    assign sin_o                 = sin_q;
    assign sample_valid_strobe_o = (state_q == S_OUTPUT);
    assign busy_o                = busy;
    assign overrun_o             = overrun_q;

endmodule

// File: tb/tb_cordic_nco_sequencer.sv
// tb/tb_cordic_nco_sequencer.sv - self-checking bench for cordic_nco_sequencer
module tb_cordic_nco_sequencer;
    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               enable_i;
    logic               tick_i;
    logic [15:0]        phase_inc_i;
    logic               phase_clr_i;
    logic signed [7:0]  cordic_x_o, cordic_y_o, cordic_z_o;
    logic               cordic_valid_strobe_o;
    logic signed [7:0]  cordic_x_i, cordic_y_i;
    logic               cordic_done_i;
    logic signed [7:0]  cos_o, sin_o;
    logic               sample_valid_strobe_o;
    logic               busy_o;
    logic               overrun_o;

    int checks = 0;
    int errors = 0;

    cordic_nco_sequencer #(.N_FRAC(7), .PHASE_BW(16), .AMPLITUDE(77)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .tick_i(tick_i),
        .phase_inc_i(phase_inc_i), .phase_clr_i(phase_clr_i),
        .cordic_x_o(cordic_x_o), .cordic_y_o(cordic_y_o), .cordic_z_o(cordic_z_o),
        .cordic_valid_strobe_o(cordic_valid_strobe_o),
        .cordic_x_i(cordic_x_i), .cordic_y_i(cordic_y_i), .cordic_done_i(cordic_done_i),
        .cos_o(cos_o), .sin_o(sin_o), .sample_valid_strobe_o(sample_valid_strobe_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view built from timestamps of the
    // expected request and result strobes plus plain integer phase arithmetic.
    int  cyc_n = 0;
    int  m_phase, m_issue, m_out;
    bit  m_active, m_pend, m_ovr, m_fold;
    int  m_x, m_y, m_z, m_cos, m_sin;

    function automatic int corr(input bit f, input int v);
        int t;
        t = f ? -v : v;
        if (t > 127) t = 127;
        return t;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_issue = -1; m_out = -1;
        m_active = 0; m_pend = 0; m_ovr = 0; m_fold = 0;
        m_x = 0; m_y = 0; m_z = 0; m_cos = 0; m_sin = 0;
    endtask

    initial model_reset();

    always @(negedge clk_i) begin
        int p;
        cyc_n++;
        if (rst_i) model_reset();
        chk("valid_strobe", cordic_valid_strobe_o, (m_active && cyc_n == m_issue) ? 1 : 0);
        chk("sample_strobe", sample_valid_strobe_o, (m_active && cyc_n == m_out) ? 1 : 0);
        chk("busy", busy_o, m_active ? 1 : 0);
        chk("overrun", overrun_o, m_ovr ? 1 : 0);
        chk("cordic_x", cordic_x_o, m_x);
        chk("cordic_y", cordic_y_o, m_y);
        chk("cordic_z", cordic_z_o, m_z);
        chk("cos", cos_o, m_cos);
        chk("sin", sin_o, m_sin);
        if (!rst_i) begin
            if (m_active) begin
                if (tick_i && enable_i) m_ovr = 1;
                if (cyc_n == m_issue) begin
                    // request just issued; results cannot be taken this cycle
                end else if (cyc_n == m_out) begin
                    m_phase  = (m_pend || phase_clr_i) ? 0 : (m_phase + int'(phase_inc_i)) % 65536;
                    m_pend   = 0;
                    m_active = 0;
                end else begin
                    if (phase_clr_i) m_pend = 1;
                    if (cordic_done_i) begin
                        m_cos = corr(m_fold, int'(cordic_x_i));
                        m_sin = corr(m_fold, int'(cordic_y_i));
                        m_out = cyc_n + 1;
                    end
                end
                if (phase_clr_i && cyc_n == m_issue) m_pend = 1;
            end else begin
                if (phase_clr_i) m_phase = 0;
                if (tick_i && enable_i) begin
                    p = m_phase >> 8;
                    if (p >= 128) p -= 256;
                    m_fold = (p >= 64) || (p < -64);
                    m_z = m_fold ? ((p >= 0) ? p - 128 : p + 128) : p;
                    m_x = 77; m_y = 0;
                    m_active = 1; m_issue = cyc_n + 1; m_out = -1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one full sample: tick, rotator stub answering after dly cycles,
    // optional extra tick / phase clear during WAIT, optional clear with the tick.
    task automatic run_sample(input int dly, input int rx, input int ry,
                              input bit tick_in_wait, input bit clr_in_wait, input bit clr_at_tick,
                              output int z, output int c, output int s);
        int n;
        tick_i = 1; phase_clr_i = clr_at_tick;
        cyc();
        tick_i = 0; phase_clr_i = 0;
        n = 0;
        while (!cordic_valid_strobe_o && n < 10) begin
            cyc();
            n++;
        end
        chk("issue_seen", cordic_valid_strobe_o, 1);
        chk("issue_x_lit", cordic_x_o, 77);
        chk("issue_y_lit", cordic_y_o, 0);
        z = int'(cordic_z_o);
        for (int i = 0; i < dly; i++) begin
            if (i == 1) begin
                tick_i = tick_in_wait;
                phase_clr_i = clr_in_wait;
            end
            cyc();
            tick_i = 0; phase_clr_i = 0;
        end
        cordic_done_i = 1; cordic_x_i = 8'(rx); cordic_y_i = 8'(ry);
        cyc();
        cordic_done_i = 0; cordic_x_i = 0; cordic_y_i = 0;
        chk("strobe_after_done", sample_valid_strobe_o, 1);
        c = int'(cos_o);
        s = int'(sin_o);
        cyc();
    endtask

    initial begin
        int z, c, s;
        int exp_z[5]    = '{0, -64, 0, -64, 0};
        bit exp_fold[5] = '{0, 1, 1, 0, 0};
        rst_i = 1; enable_i = 0; tick_i = 0; phase_inc_i = 0; phase_clr_i = 0;
        cordic_x_i = 0; cordic_y_i = 0; cordic_done_i = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        chk("reset_busy", busy_o, 0);
        chk("reset_cos", cos_o, 0);

        // Phase 0, rotator answers (127, 0) after 8 cycles.
        enable_i = 1;
        run_sample(8, 127, 0, 0, 0, 0, z, c, s);
        chk("a_z_lit", z, 0);
        chk("a_cos_lit", c, 127);
        chk("a_sin_lit", s, 0);

        // Quarter-turn steps through all four quadrants.
        phase_inc_i = 16'h4000;
        for (int k = 0; k < 5; k++) begin
            run_sample(3 + k, -100, 50, 0, 0, 0, z, c, s);
            chk("b_z_lit", z, exp_z[k]);
            chk("b_cos_lit", c, exp_fold[k] ? 100 : -100);
            chk("b_sin_lit", s, exp_fold[k] ? -50 : 50);
        end

        // Phase is back at 0x4000 (folding): saturation of -(-128).
        phase_inc_i = 0;
        run_sample(2, -128, -128, 0, 0, 0, z, c, s);
        chk("c_z_lit", z, -64);
        chk("c_cos_sat_lit", c, 127);
        chk("c_sin_sat_lit", s, 127);

        // Tick during WAIT: dropped, overrun sticks.
        run_sample(4, 10, 20, 1, 0, 0, z, c, s);
        chk("d_overrun_lit", overrun_o, 1);
        chk("d_cos_lit", c, -10);
        run_sample(2, 10, 20, 0, 0, 0, z, c, s);
        chk("d_overrun_sticky_lit", overrun_o, 1);

        // Phase clear: idle clear, then clear pending during WAIT.
        phase_clr_i = 1;
        cyc();
        phase_clr_i = 0;
        phase_inc_i = 16'h1000;
        run_sample(4, 1, 2, 0, 1, 0, z, c, s);
        chk("e_z0_lit", z, 0);
        run_sample(3, 1, 2, 0, 0, 0, z, c, s);
        chk("e_z_cleared_lit", z, 0);
        run_sample(3, 1, 2, 0, 0, 0, z, c, s);
        chk("e_z_inc_lit", z, 16);
        run_sample(3, 1, 2, 0, 0, 1, z, c, s);
        chk("e_z_clr_tick_lit", z, 0);

        // Reset mid-WAIT; the late done must be ignored.
        tick_i = 1;
        cyc();
        tick_i = 0;
        cyc();
        cyc();
        rst_i = 1;
        cyc();
        rst_i = 0;
        cordic_done_i = 1; cordic_x_i = 55; cordic_y_i = 66;
        cyc();
        cordic_done_i = 0;
        chk("f_no_strobe_lit", sample_valid_strobe_o, 0);
        chk("f_busy_lit", busy_o, 0);
        chk("f_overrun_lit", overrun_o, 0);
        chk("f_cos_lit", cos_o, 0);
        chk("f_z_lit", cordic_z_o, 0);
        cyc();

        // Randomized traffic; the per-cycle compare against the model does the checking.
        for (int i = 0; i < 4000; i++) begin
            enable_i      = ($urandom % 8) != 0;
            tick_i        = ($urandom % 4) == 0;
            phase_clr_i   = ($urandom % 16) == 0;
            cordic_done_i = ($urandom % 5) == 0;
            cordic_x_i    = 8'($urandom);
            cordic_y_i    = 8'($urandom);
            if (($urandom % 8) == 0) phase_inc_i = 16'($urandom);
            cyc();
        end
        tick_i = 0; phase_clr_i = 0; cordic_done_i = 0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
